// File: rtl/mem_arbiter.sv
// Three-requester round-robin arbiter in front of a single-port memory.
// One transaction in flight: IDLE -> ACCESS -> WAIT (MEM_LAT cycles) -> RESP.
`timescale 1ns/1ps
module mem_arbiter #(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [95:0] addr,
    input  logic [2:0]  wr,
    input  logic [95:0] wdata,
    input  logic [11:0] mask,
    output logic [2:0]  gnt,
    output logic [2:0]  rvalid,
    output logic [31:0] rdata,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_mask,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam logic [2:0] LAT = 3'(MEM_LAT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_RESP
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  last_q, last_d;
    logic [1:0]  win_q, win_d;
    logic        wr_q, wr_d;
    logic [29:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  mask_q, mask_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;

    logic [1:0]  c0, c1, c2, pick;
    logic        pick_wr;
    logic [29:0] pick_addr;
    logic [31:0] pick_wdata;
    logic [3:0]  pick_mask;

    function automatic logic [1:0] inc3(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    // Search order begins just after the last winner.
    always_comb begin
        c0 = inc3(last_q);
        c1 = inc3(c0);
        c2 = inc3(c1);
        if (req[c0]) begin
            pick = c0;
        end else if (req[c1]) begin
            pick = c1;
        end else begin
            pick = c2;
        end
    end

    always_comb begin
        pick_wr    = wr[0];
        pick_addr  = addr[31:2];
        pick_wdata = wdata[31:0];
        pick_mask  = mask[3:0];
        unique case (pick)
            2'd1: begin
                pick_wr    = wr[1];
                pick_addr  = addr[63:34];
                pick_wdata = wdata[63:32];
                pick_mask  = mask[7:4];
            end
            2'd2: begin
                pick_wr    = wr[2];
                pick_addr  = addr[95:66];
                pick_wdata = wdata[95:64];
                pick_mask  = mask[11:8];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        win_d   = win_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (|req) begin
                    state_d = S_ACCESS;
                    win_d   = pick;
                    wr_d    = pick_wr;
                    addr_d  = pick_addr;
                    wdata_d = pick_wdata;
                    mask_d  = pick_mask;
                end
            end
            S_ACCESS: begin
                state_d = S_WAIT;
                cnt_d   = LAT;
            end
            S_WAIT: begin
                if (cnt_q <= 3'd1) begin
                    state_d = S_RESP;
                    cnt_d   = 3'd0;
                    if (!wr_q) begin
                        rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                last_d  = win_q;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            last_q  <= 2'd2;
            win_q   <= 2'd0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            win_q   <= win_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    logic acc, rsp;
    assign acc = (state_q == S_ACCESS);
    assign rsp = (state_q == S_RESP);

    // Memory-side outputs are forced to zero outside ACCESS.
    assign gnt       = acc ? (3'b001 << win_q) : 3'b000;
    assign rvalid    = rsp ? (3'b001 << win_q) : 3'b000;
    assign mem_en    = acc;
    assign mem_wr    = acc & wr_q;
    assign mem_addr  = acc ? {addr_q, 2'b00} : 32'h0;
    assign mem_wdata = acc ? wdata_q : 32'h0;
    assign mem_mask  = (acc & wr_q) ? mask_q : 4'h0;
    assign rdata     = rdata_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at MEM_LAT=1, one at MEM_LAT=4,
// sharing requester and memory inputs.
`timescale 1ns/1ps
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req;
    logic [95:0] addr;
    logic [2:0]  wr;
    logic [95:0] wdata;
    logic [11:0] mask;
    logic [31:0] mem_rdata;

    logic [2:0]  gnt1, rvalid1, gnt4, rvalid4;
    logic [31:0] rdata1, rdata4;
    logic        mem_en1, mem_wr1, busy1, mem_en4, mem_wr4, busy4;
    logic [31:0] mem_addr1, mem_wdata1, mem_addr4, mem_wdata4;
    logic [3:0]  mem_mask1, mem_mask4;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.MEM_LAT(1)) u1 (
        .clk(clk), .reset(reset), .req(req), .addr(addr), .wr(wr),
        .wdata(wdata), .mask(mask), .gnt(gnt1), .rvalid(rvalid1),
        .rdata(rdata1), .mem_en(mem_en1), .mem_wr(mem_wr1),
        .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_mask(mem_mask1), .mem_rdata(mem_rdata), .busy(busy1)
    );

    mem_arbiter #(.MEM_LAT(4)) u4 (
        .clk(clk), .reset(reset), .req(req), .addr(addr), .wr(wr),
        .wdata(wdata), .mask(mask), .gnt(gnt4), .rvalid(rvalid4),
        .rdata(rdata4), .mem_en(mem_en4), .mem_wr(mem_wr4),
        .mem_addr(mem_addr4), .mem_wdata(mem_wdata4),
        .mem_mask(mem_mask4), .mem_rdata(mem_rdata), .busy(busy4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #1;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        int lat, en_cnt, rv_cnt, bad, n, prev;
        logic [2:0] exp_seq [4];
        exp_seq[0] = 3'b001;
        exp_seq[1] = 3'b010;
        exp_seq[2] = 3'b100;
        exp_seq[3] = 3'b001;

        reset = 1'b0;
        req = '0; addr = '0; wr = '0; wdata = '0; mask = '0;
        mem_rdata = '0;
        #12;
        chk("rst_busy", 32'(busy1), 32'h0);
        chk("rst_gnt", 32'(gnt1), 32'h0);
        chk("rst_rvalid", 32'(rvalid1), 32'h0);
        chk("rst_rdata", rdata1, 32'h0);
        chk("rst_mem_en", 32'(mem_en1), 32'h0);
        chk("rst_busy4", 32'(busy4), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Read, MEM_LAT=1
        req = 3'b001;
        addr[31:0] = 32'h0000_0010;
        mem_rdata = 32'hDEAD_BEEF;
        tick();
        chk("rd_gnt", 32'(gnt1), 32'h1);
        chk("rd_mem_en", 32'(mem_en1), 32'h1);
        chk("rd_mem_addr", mem_addr1, 32'h10);
        chk("rd_mem_wr", 32'(mem_wr1), 32'h0);
        chk("rd_mem_mask", 32'(mem_mask1), 32'h0);
        req = 3'b000;
        tick();
        chk("rd_wait_gnt", 32'(gnt1), 32'h0);
        chk("rd_wait_rvalid", 32'(rvalid1), 32'h0);
        chk("rd_wait_busy", 32'(busy1), 32'h1);
        tick();
        chk("rd_rvalid", 32'(rvalid1), 32'h1);
        chk("rd_rdata", rdata1, 32'hDEAD_BEEF);
        tick();
        chk("rd_idle_rvalid", 32'(rvalid1), 32'h0);
        chk("rd_idle_busy", 32'(busy1), 32'h0);

        // Write from requester 1; inputs change right after grant
        req = 3'b010;
        wr = 3'b010;
        addr[63:32] = 32'h0000_0023;
        wdata[63:32] = 32'h1234_5678;
        mask[7:4] = 4'hF;
        mem_rdata = 32'h55AA_55AA;
        tick();
        chk("wr_gnt", 32'(gnt1), 32'h2);
        chk("wr_mem_wr", 32'(mem_wr1), 32'h1);
        chk("wr_mem_wdata", mem_wdata1, 32'h1234_5678);
        chk("wr_mem_mask", 32'(mem_mask1), 32'hF);
        chk("wr_mem_addr", mem_addr1, 32'h20);
        req = 3'b000; wr = 3'b000; wdata = '1; mask = '0;
        tick();
        chk("wr_wait_mem_en", 32'(mem_en1), 32'h0);
        tick();
        chk("wr_rvalid", 32'(rvalid1), 32'h2);
        chk("wr_rdata_kept", rdata1, 32'hDEAD_BEEF);
        tick();

        // Latency, MEM_LAT=4
        pulse_reset();
        req = 3'b001;
        addr[31:0] = 32'h0000_0040;
        mem_rdata = 32'hCAFE_F00D;
        lat = 0;
        en_cnt = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (mem_en4) en_cnt++;
            if (i == 1) req = 3'b000;
            lat = i;
            if (rvalid4 != 3'b000) break;
        end
        chk("lat4_cycles", 32'(lat), 32'd6);
        chk("lat4_mem_en_len", 32'(en_cnt), 32'd1);
        chk("lat4_rvalid", 32'(rvalid4), 32'h1);
        chk("lat4_rdata", rdata4, 32'hCAFE_F00D);

        // Reset abort during WAIT
        pulse_reset();
        req = 3'b001;
        addr[31:0] = 32'h0000_0080;
        mem_rdata = 32'h1111_1111;
        tick();
        req = 3'b000;
        tick();
        tick();
        chk("abort_busy_pre", 32'(busy4), 32'h1);
        reset = 1'b0;
        #1;
        chk("abort_busy", 32'(busy4), 32'h0);
        chk("abort_rdata", rdata4, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        rv_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (rvalid4 != 3'b000) rv_cnt++;
        end
        chk("abort_no_rvalid", 32'(rv_cnt), 32'd0);
        req = 3'b100;
        addr[95:64] = 32'h0000_0104;
        tick();
        chk("abort_next_gnt", 32'(gnt4), 32'h4);
        chk("abort_next_addr", mem_addr4, 32'h104);

        // Request raised only during WAIT and dropped
        req = 3'b000;
        tick();
        req = 3'b010;
        tick();
        req = 3'b000;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (gnt4[1] || gnt1[1]) bad++;
        end
        chk("drop_no_gnt1", 32'(bad), 32'd0);

        // Fairness, MEM_LAT=1
        pulse_reset();
        req = 3'b111;
        wr = 3'b000;
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (gnt1 == 3'b000 && n < 20) begin
                tick();
                n++;
            end
            chk($sformatf("fair_gnt%0d", k), 32'(gnt1), 32'(exp_seq[k]));
            chk($sformatf("fair_onehot%0d", k),
                32'($onehot0(gnt4) && $onehot0(rvalid1)), 32'h1);
            if (k > 0) begin
                chk($sformatf("fair_gap%0d", k), 32'(cyc - prev), 32'd4);
            end
            prev = cyc;
            tick();
        end
        req = 3'b000;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_LAT, default 1, meaning memory read latency in cycles from mem_en to valid mem_rdata; legal range 1..4.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous and active-low (reset=0 clears all state immediately).
REQ-004 SHALL have port req  input  3  per-requester request; bit 0 = data port, bit 1 = instruction fetch, bit 2 = debug loader.
REQ-005 SHALL have port addr  input  96  packed byte addresses, requester i at bits [32i+31:32i].
REQ-006 SHALL have port wr  input  3  per-requester write (1) / read (0).
REQ-007 SHALL have port wdata  input  96  packed write data, 32 bits per requester.
REQ-008 SHALL have port mask  input  12  packed byte-enables, 4 bits per requester.
REQ-009 SHALL have port gnt  output  3  one-hot grant pulse.
REQ-010 SHALL have port rvalid  output  3  one-hot completion pulse, issued for both reads and writes.
REQ-011 SHALL have port rdata  output  32  read data for the requester flagged by rvalid.
REQ-012 SHALL have port mem_en  output  1  memory access strobe.
REQ-013 SHALL have port mem_wr  output  1  memory write enable.
REQ-014 SHALL have port mem_addr  output  32  memory word-aligned address.
REQ-015 SHALL have port mem_wdata  output  32  memory write data.
REQ-016 SHALL have port mem_mask  output  4  memory byte-enables.
REQ-017 SHALL have port mem_rdata  input  32  memory read data.
REQ-018 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-019 SHALL implement states IDLE, ACCESS, WAIT, RESP; at most one transaction outstanding.
REQ-020 IDLE: if req!=0, SHALL select winner w by round-robin and go to ACCESS; else stay in IDLE.
REQ-021 Round-robin: search order SHALL start at (last+1) mod 3, where last = most recently granted index.
REQ-022 SHALL sample req only in IDLE; a request dropped before grant is never granted.
REQ-023 ACCESS (1 cycle): SHALL drive mem_en=1, gnt[w]=1, mem_wr=wr[w], mem_addr={addr_w[31:2],2'b00}, mem_wdata=wdata_w, mem_mask=mask_w if write else 4'b0000.
REQ-024 ACCESS SHALL register the winner's wr, address, data and mask at the IDLE->ACCESS edge; requester inputs may change after gnt without effect.
REQ-025 WAIT: a down-counter loaded with MEM_LAT SHALL expire after exactly MEM_LAT cycles; on expiry SHALL capture mem_rdata into rdata if a read, then go to RESP.
REQ-026 RESP (1 cycle): SHALL assert rvalid[w]=1, then go to IDLE and set last=w.
REQ-027 Latency: req seen in IDLE at cycle N -> gnt/mem_en at N+1 -> rvalid at N+2+MEM_LAT.
REQ-028 For writes, rdata SHALL be left unchanged.
REQ-029 rdata SHALL hold its value until the next read completion.
REQ-030 Outside ACCESS, mem_en, mem_wr, mem_mask and gnt SHALL be 0.
REQ-031 Outside RESP, rvalid SHALL be 0.
REQ-032 gnt and rvalid SHALL each be one-hot or zero in every cycle.

Reset
REQ-033 reset=0 SHALL force IDLE, last=2 (so requester 0 wins first), counter=0, and all outputs 0 (rdata=32'h0), regardless of clock.
REQ-034 Reset mid-transaction SHALL abort it; no rvalid SHALL be issued for the aborted access after release.
REQ-035 The first arbitration SHALL occur on the first rising edge with reset=1.

Verification
REQ-036 Read, MEM_LAT=1: req=3'b001, addr0=32'h0000_0010, mem_rdata=32'hDEAD_BEEF -> gnt=001 and mem_addr=32'h10 at N+1, rvalid=001 and rdata=32'hDEAD_BEEF at N+3.
REQ-037 Write: req=3'b010, wr=3'b010, wdata1=32'h1234_5678, mask1=4'hF -> at gnt: mem_wr=1, mem_wdata=32'h1234_5678, mem_mask=4'hF; rvalid=010; rdata unchanged.
REQ-038 Fairness: req=3'b111 held continuously after reset -> grant sequence 001, 010, 100, 001; one grant per 3+MEM_LAT cycles.
REQ-039 Latency: MEM_LAT=4 -> rvalid exactly 6 cycles after the IDLE sample; mem_en high for exactly 1 cycle.
REQ-040 Reset abort: assert reset=0 during WAIT -> busy=0 immediately; no rvalid afterward; next req=3'b100 is granted first.
REQ-041 Dropped request: req=3'b010 for 1 cycle while in WAIT, then 0 -> no gnt to requester 1.
